// File: rtl/sprite_table.sv
// Double-buffered sprite descriptor table with a two-stage per-pixel hit pipeline.
// Game logic writes the shadow bank; new_frame commits it to the active bank.
module sprite_table #(
  parameter int NUM_SPRITES         = 8,
  parameter int SPRITE_FRAME_WIDTH  = 192,
  parameter int SPRITE_FRAME_HEIGHT = 128,
  parameter int NUM_FRAMES          = 23,
  parameter int IDX_W               = $clog2(NUM_SPRITES),
  parameter int FR_W                = $clog2(NUM_FRAMES),
  localparam int DX_W               = $clog2(SPRITE_FRAME_WIDTH),
  localparam int DY_W               = $clog2(SPRITE_FRAME_HEIGHT)
) (
  input  logic             clk_pixel,
  input  logic             sys_rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_sprite_valid,
  input  logic [10:0]      wr_x,
  input  logic [9:0]       wr_y,
  input  logic [FR_W-1:0]  wr_frame,
  input  logic             new_frame,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  input  logic             active_draw,
  output logic             hit_out,
  output logic [IDX_W-1:0] hit_index,
  output logic [FR_W-1:0]  hit_frame,
  output logic [DX_W-1:0]  hit_dx,
  output logic [DY_W-1:0]  hit_dy,
  output logic [IDX_W:0]   hit_count,
  output logic             ad_out,
  output logic             err_out
);

  typedef struct packed {
    logic            vld;
    logic [10:0]     x;
    logic [9:0]      y;
    logic [FR_W-1:0] fr;
  } desc_t;

  localparam logic [IDX_W:0] NS = (IDX_W+1)'(NUM_SPRITES);

  desc_t shadow_q [NUM_SPRITES];
  desc_t active_q [NUM_SPRITES];
  logic  err_q;
  logic  wr_fire;
  logic  wr_oor;

  assign wr_ready = sys_rst_n & ~new_frame;
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_oor   = {1'b0, wr_index} >= NS;

  // new_frame stalls the write port, so commit and write never share an edge
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else if (new_frame) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        active_q[i] <= shadow_q[i];
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_SPRITES; i++)
        if (wr_index == IDX_W'(i))
          shadow_q[i] <= {wr_sprite_valid, wr_x, wr_y, wr_frame};
      if (wr_oor)
        err_q <= 1'b1;
    end
  end

  assign err_out = err_q;

  logic [10:0] hc_q;
  logic [9:0]  vc_q;
  logic        ad1_q;

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      ad1_q <= 1'b0;
    end else begin
      hc_q  <= hcount;
      vc_q  <= vcount;
      ad1_q <= active_draw;
    end
  end

  logic [NUM_SPRITES-1:0] cov;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W:0]         cnt;
  logic [10:0]            dxf;
  logic [9:0]             dyf;
  logic                   hit_d;
  logic [IDX_W-1:0]       idx_d;
  logic [FR_W-1:0]        fr_d;
  logic [DX_W-1:0]        dx_d;
  logic [DY_W-1:0]        dy_d;
  logic [IDX_W:0]         cnt_d;

  // widened end-edge sums keep sprites near the screen limit from wrapping
  always_comb begin
    cov = '0;
    sel = '0;
    cnt = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      cov[i] = active_q[i].vld
        && ({1'b0, hc_q} >= {1'b0, active_q[i].x})
        && ({1'b0, hc_q} < {1'b0, active_q[i].x} + 12'(SPRITE_FRAME_WIDTH))
        && ({1'b0, vc_q} >= {1'b0, active_q[i].y})
        && ({1'b0, vc_q} < {1'b0, active_q[i].y} + 11'(SPRITE_FRAME_HEIGHT));
      cnt = cnt + (IDX_W+1)'(cov[i]);
    end
    for (int i = NUM_SPRITES-1; i >= 0; i--)
      if (cov[i])
        sel = IDX_W'(i);
    dxf   = hc_q - active_q[sel].x;
    dyf   = vc_q - active_q[sel].y;
    hit_d = ad1_q & (|cov);
    idx_d = '0;
    fr_d  = '0;
    dx_d  = '0;
    dy_d  = '0;
    cnt_d = '0;
    if (hit_d) begin
      idx_d = sel;
      fr_d  = active_q[sel].fr;
      dx_d  = dxf[DX_W-1:0];
      dy_d  = dyf[DY_W-1:0];
      cnt_d = cnt;
    end
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hit_out   <= 1'b0;
      hit_index <= '0;
      hit_frame <= '0;
      hit_dx    <= '0;
      hit_dy    <= '0;
      hit_count <= '0;
      ad_out    <= 1'b0;
    end else begin
      hit_out   <= hit_d;
      hit_index <= idx_d;
      hit_frame <= fr_d;
      hit_dx    <= dx_d;
      hit_dy    <= dy_d;
      hit_count <= cnt_d;
      ad_out    <= ad1_q;
    end
  end

endmodule

// File: tb/tb_sprite_table.sv
// Bench for sprite_table: directed scenarios plus random traffic,
// checked every cycle against a behavioural table model.
module tb_sprite_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_index = '0;
  logic        wr_sv = 1'b0;
  logic [10:0] wr_x = '0;
  logic [9:0]  wr_y = '0;
  logic [4:0]  wr_frame = '0;
  logic        new_frame = 1'b0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        active_draw = 1'b0;

  logic       rdy8, h8, ad8, err8;
  logic [2:0] hi8;
  logic [4:0] hf8;
  logic [7:0] dx8;
  logic [6:0] dy8;
  logic [3:0] hc8;
  logic       rdy6, h6, ad6, err6;
  logic [2:0] hi6;
  logic [4:0] hf6;
  logic [7:0] dx6;
  logic [6:0] dy6;
  logic [3:0] hc6;

  always #5 clk = ~clk;

  sprite_table dut (
    .clk_pixel(clk), .sys_rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(rdy8),
    .wr_index(wr_index), .wr_sprite_valid(wr_sv),
    .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame),
    .new_frame(new_frame),
    .hcount(hcount), .vcount(vcount),
    .active_draw(active_draw),
    .hit_out(h8), .hit_index(hi8), .hit_frame(hf8),
    .hit_dx(dx8), .hit_dy(dy8), .hit_count(hc8),
    .ad_out(ad8), .err_out(err8)
  );

  sprite_table #(.NUM_SPRITES(6)) dut6 (
    .clk_pixel(clk), .sys_rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(rdy6),
    .wr_index(wr_index), .wr_sprite_valid(wr_sv),
    .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame),
    .new_frame(new_frame),
    .hcount(hcount), .vcount(vcount),
    .active_draw(active_draw),
    .hit_out(h6), .hit_index(hi6), .hit_frame(hf6),
    .hit_dx(dx6), .hit_dy(dy6), .hit_count(hc6),
    .ad_out(ad6), .err_out(err6)
  );

  int total = 0;
  int bad = 0;

  task automatic cmp(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", n, a, e, $time);
    end
  endtask

  typedef struct {
    bit v;
    int x;
    int y;
    int fr;
  } desc_t;

  typedef struct {
    bit hit;
    int idx;
    int fr;
    int dx;
    int dy;
    int cnt;
    bit ad;
  } exp_t;

  desc_t sh [8];
  desc_t ac [8];
  int    p_h, p_v;
  bit    p_a;
  bit    m_err6;
  exp_t  e8, e6;

  // Topmost covering sprite among the first n active slots, for the pixel in stage 1.
  function automatic exp_t calc(input int n);
    exp_t r;
    int first;
    r = '{default: 0};
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (ac[i].v && p_h >= ac[i].x && p_h < ac[i].x + 192
          && p_v >= ac[i].y && p_v < ac[i].y + 128) begin
        r.cnt++;
        if (first < 0) first = i;
      end
    end
    r.ad = p_a;
    if (p_a && first >= 0) begin
      r.hit = 1;
      r.idx = first;
      r.fr  = ac[first].fr;
      r.dx  = p_h - ac[first].x;
      r.dy  = p_v - ac[first].y;
    end else begin
      r.cnt = 0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        sh[i] = '{default: 0};
        ac[i] = '{default: 0};
      end
      p_h = 0; p_v = 0; p_a = 0;
      m_err6 = 0;
      e8 = '{default: 0};
      e6 = '{default: 0};
    end else begin
      e8 = calc(8);
      e6 = calc(6);
      if (new_frame) begin
        for (int i = 0; i < 8; i++) ac[i] = sh[i];
      end else if (wr_valid) begin
        sh[wr_index] = '{wr_sv, int'(wr_x), int'(wr_y), int'(wr_frame)};
        if (wr_index >= 6) m_err6 = 1;
      end
      p_h = hcount;
      p_v = vcount;
      p_a = active_draw;
    end
  end

  always @(negedge clk) begin
    cmp("rdy8", rdy8, int'(rst_n && !new_frame));
    cmp("rdy6", rdy6, int'(rst_n && !new_frame));
    cmp("hit8", h8, e8.hit);
    cmp("idx8", hi8, e8.idx);
    cmp("fr8", hf8, e8.fr);
    cmp("dx8", dx8, e8.dx);
    cmp("dy8", dy8, e8.dy);
    cmp("cnt8", hc8, e8.cnt);
    cmp("ad8", ad8, e8.ad);
    cmp("err8", err8, 0);
    cmp("hit6", h6, e6.hit);
    cmp("idx6", hi6, e6.idx);
    cmp("fr6", hf6, e6.fr);
    cmp("dx6", dx6, e6.dx);
    cmp("dy6", dy6, e6.dy);
    cmp("cnt6", hc6, e6.cnt);
    cmp("ad6", ad6, e6.ad);
    cmp("err6", err6, int'(m_err6));
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int i, input bit v, input int x, input int y, input int f);
    wr_valid = 1; wr_index = 3'(i); wr_sv = v;
    wr_x = 11'(x); wr_y = 10'(y); wr_frame = 5'(f);
    tick();
    wr_valid = 0;
  endtask

  task automatic commit;
    new_frame = 1;
    tick();
    new_frame = 0;
  endtask

  task automatic pix(input int h, input int v, input bit a);
    hcount = 11'(h); vcount = 10'(v); active_draw = a;
    tick();
    tick();
  endtask

  task automatic lit(input string n, input int h, input int i, input int f,
                     input int dx, input int dy, input int c);
    cmp({n, ".hit"}, h8, h);
    cmp({n, ".idx"}, hi8, i);
    cmp({n, ".fr"}, hf8, f);
    cmp({n, ".dx"}, dx8, dx);
    cmp({n, ".dy"}, dy8, dy);
    cmp({n, ".cnt"}, hc8, c);
  endtask

  initial begin
    repeat (3) tick();
    lit("rst", 0, 0, 0, 0, 0, 0);
    cmp("rst.rdy", rdy8, 0);
    cmp("rst.err", err6, 0);
    rst_n = 1;
    tick();

    wr(3, 1, 100, 200, 3);
    commit();
    pix(100, 200, 1);
    lit("t1a", 1, 3, 3, 0, 0, 1);
    pix(291, 327, 1);
    lit("t1b", 1, 3, 3, 191, 127, 1);
    pix(292, 200, 1);
    lit("t1c", 0, 0, 0, 0, 0, 0);

    wr(1, 1, 0, 0, 7);
    wr(5, 1, 0, 0, 9);
    commit();
    pix(10, 10, 1);
    lit("t2a", 1, 1, 7, 10, 10, 2);
    wr(1, 0, 0, 0, 0);
    commit();
    pix(10, 10, 1);
    lit("t2b", 1, 5, 9, 10, 10, 1);

    wr(2, 1, 400, 400, 4);
    pix(410, 405, 1);
    lit("t3a", 0, 0, 0, 0, 0, 0);
    commit();
    pix(410, 405, 1);
    lit("t3b", 1, 2, 4, 10, 5, 1);
    cmp("t3.err6pre", err6, 0);
    wr_valid = 1; wr_index = 3'd6; wr_sv = 1;
    wr_x = 11'd600; wr_y = 10'd50; wr_frame = 5'd11;
    new_frame = 1;
    #1 cmp("t3.stall", rdy8, 0);
    #1;
    tick();
    new_frame = 0;
    #1 cmp("t3.go", rdy8, 1);
    #1;
    tick();
    wr_valid = 0;
    pix(600, 50, 1);
    lit("t3c", 0, 0, 0, 0, 0, 0);
    commit();
    pix(600, 50, 1);
    lit("t3d", 1, 6, 11, 0, 0, 1);
    cmp("t3.err6", err6, 1);
    cmp("t3.hit6", h6, 0);

    wr(5, 0, 0, 0, 0);
    wr(0, 1, 1200, 700, 1);
    commit();
    pix(1279, 719, 1);
    lit("t4a", 1, 0, 1, 79, 19, 1);
    pix(0, 0, 1);
    lit("t4b", 0, 0, 0, 0, 0, 0);
    cmp("t4.err6", err6, 1);

    pix(1279, 719, 1);
    active_draw = 0;
    tick();
    cmp("t6.hit1", h8, 1);
    cmp("t6.ad1", ad8, 1);
    tick();
    cmp("t6.hit2", h8, 0);
    cmp("t6.ad2", ad8, 0);

    for (int n = 0; n < 3000; n++) begin
      bit wide;
      wide = ($urandom % 4) == 0;
      wr_valid  = ($urandom % 10) < 3;
      wr_index  = 3'($urandom % 8);
      wr_sv     = ($urandom % 4) != 0;
      wr_x      = 11'(wide ? $urandom_range(0, 1400) : $urandom_range(0, 600));
      wr_y      = 10'(wide ? $urandom_range(0, 800) : $urandom_range(0, 400));
      wr_frame  = 5'($urandom_range(0, 22));
      new_frame = ($urandom % 20) == 0;
      hcount    = 11'(wide ? $urandom_range(0, 1500) : $urandom_range(0, 800));
      vcount    = 10'(wide ? $urandom_range(0, 900) : $urandom_range(0, 530));
      active_draw = ($urandom % 8) != 0;
      if (n == 1500) begin
        #1 rst_n = 0;
        #1;
        lit("rst2", 0, 0, 0, 0, 0, 0);
        cmp("rst2.ad", ad8, 0);
        cmp("rst2.err6", err6, 0);
        cmp("rst2.rdy", rdy8, 0);
        tick();
        rst_n = 1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
